// File: rtl/pri_arb.sv
// Fixed-priority N-way arbiter (bit 0 highest) with a DELAY-stage registered grant pipeline.
// Define PRI_ARB_ASSERT_EN to compile the built-in concurrent assertions.
module pri_arb #(
   parameter int N     = 3,
   parameter int DELAY = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] req,
   output logic [N-1:0] gnt
);

   // Clamped depth keeps declarations legal so the parameter error below is the one reported.
   localparam int DEPTH = (DELAY < 1) ? 1 : DELAY;

   generate
      if (DELAY < 1) begin : g_bad_delay
         $error("pri_arb: DELAY must be >= 1 (got %0d)", DELAY);
      end
      if (N < 1) begin : g_bad_n
         $error("pri_arb: N must be >= 1 (got %0d)", N);
      end
   endgenerate

   logic [N-1:0] w_enc;
   logic [N-1:0] r_stage [DEPTH];

   always_comb begin
      logic v_found;
      w_enc   = '0;
      v_found = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (req[i] && !v_found) begin
            w_enc[i] = 1'b1;
            v_found  = 1'b1;
         end
      end
   end

   // Stage 0 captures the encoded request; later stages are a plain shift chain.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
         if (gi == 0) begin : g_first
            always_ff @(posedge clk or negedge rst_n) begin
               if (!rst_n) begin
                  r_stage[gi] <= '0;
               end else begin
                  r_stage[gi] <= w_enc;
               end
            end
         end else begin : g_next
            always_ff @(posedge clk or negedge rst_n) begin
               if (!rst_n) begin
                  r_stage[gi] <= '0;
               end else begin
                  r_stage[gi] <= r_stage[gi-1];
               end
            end
         end
      end
   endgenerate

   assign gnt = r_stage[DEPTH-1];

`ifdef PRI_ARB_ASSERT_EN
   a_gnt_onehot0 : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt))
      else $error("pri_arb: gnt not onehot0, req=%b gnt=%b", $sampled(req), $sampled(gnt));

   a_gnt_latency : assert property (@(posedge clk) disable iff (!rst_n)
      (req != $past(req)) |-> ##DELAY (gnt == $past(w_enc, DELAY)))
      else $error("pri_arb: latency mismatch, req=%b gnt=%b", $past(req, DELAY), $sampled(gnt));
`endif

endmodule

// File: tb/tb_pri_arb.sv
// Self-checking bench for pri_arb: three instances (DELAY = 1, 2, 5) share req and rst_n,
// checked against stimulus tables and a sample-history reference model.
module tb_pri_arb;

   logic       clk;
   logic       rst_n;
   logic [2:0] req;
   logic [2:0] gnt_d1;
   logic [2:0] gnt_d2;
   logic [2:0] gnt_d5;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [2:0] req;
      logic [2:0] gnt;
   } vec_t;

   vec_t tbl [8];
   int   tbl_len;

   // Every req value sampled since the last reset, oldest first.
   logic [2:0] hist [$];

   pri_arb #(.N(3), .DELAY(1)) u_d1 (.clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt_d1));
   pri_arb #(.N(3), .DELAY(2)) u_d2 (.clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt_d2));
   pri_arb #(.N(3), .DELAY(5)) u_d5 (.clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt_d5));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int dly(input int k);
      return (k == 0) ? 1 : (k == 1) ? 2 : 5;
   endfunction

   function automatic logic [2:0] gnt_of(input int k);
      return (k == 0) ? gnt_d1 : (k == 1) ? gnt_d2 : gnt_d5;
   endfunction

   // Lowest set bit isolated arithmetically: r & (two's complement of r).
   function automatic logic [2:0] model_gnt(input int d);
      logic [2:0] r;
      int n;
      n = hist.size();
      if (n < d) return 3'b000;
      r = hist[n-d];
      return r & (~r + 3'd1);
   endfunction

   task automatic chk(input string name, input int d, input logic [2:0] act, input logic [2:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s (DELAY=%0d): gnt=%b expected=%b", name, d, act, exp);
      end else begin
         $display("ok   %s (DELAY=%0d): req=%b gnt=%b", name, d, req, act);
      end
   endtask

   task automatic chk_quiet(input string name, input int d, input logic [2:0] act, input logic [2:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s (DELAY=%0d): req=%b gnt=%b expected=%b", name, d, req, act, exp);
      end
   endtask

   // Drive r, clock one edge, then compare every instance with the model.
   task automatic step(input logic [2:0] r, input bit verbose);
      req = r;
      @(posedge clk);
      if (rst_n) hist.push_back(r);
      if (hist.size() > 8) void'(hist.pop_front());
      #1;
      for (int k = 0; k < 3; k++) begin
         if (verbose) chk("model", dly(k), gnt_of(k), model_gnt(dly(k)));
         else         chk_quiet("model", dly(k), gnt_of(k), model_gnt(dly(k)));
         checks++;
         if (!$onehot0(gnt_of(k))) begin
            errors++;
            $display("FAIL onehot0 (DELAY=%0d): gnt=%b expected one-hot or zero", dly(k), gnt_of(k));
         end
      end
   endtask

   // Apply the table one entry per edge; grant for entry i must show after edge i+DELAY-1.
   task automatic run_tbl(input string name);
      int idx;
      for (int j = 0; j < tbl_len + 5; j++) begin
         step((j < tbl_len) ? tbl[j].req : 3'b000, 1'b0);
         for (int k = 0; k < 3; k++) begin
            idx = j - dly(k) + 1;
            if (idx >= 0 && idx < tbl_len) chk(name, dly(k), gnt_of(k), tbl[idx].gnt);
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      req   = 3'b111;

      // Reset held with all requests asserted: grants stay zero.
      repeat (3) begin
         @(posedge clk);
         #1;
         for (int k = 0; k < 3; k++) chk("reset_hold", dly(k), gnt_of(k), 3'b000);
      end
      rst_n = 1'b1;
      for (int j = 1; j <= 6; j++) begin
         step(3'b111, 1'b0);
         for (int k = 0; k < 3; k++)
            chk("reset_release", dly(k), gnt_of(k), (j >= dly(k)) ? 3'b001 : 3'b000);
      end

      // Single-request sequence.
      tbl[0] = '{3'b001, 3'b001};
      tbl[1] = '{3'b010, 3'b010};
      tbl[2] = '{3'b000, 3'b000};
      tbl[3] = '{3'b000, 3'b000};
      tbl[4] = '{3'b111, 3'b001};
      tbl_len = 5;
      run_tbl("single_seq");

      // Priority sweep over all request values.
      tbl[0] = '{3'b000, 3'b000};
      tbl[1] = '{3'b001, 3'b001};
      tbl[2] = '{3'b010, 3'b010};
      tbl[3] = '{3'b011, 3'b001};
      tbl[4] = '{3'b100, 3'b100};
      tbl[5] = '{3'b101, 3'b001};
      tbl[6] = '{3'b110, 3'b010};
      tbl[7] = '{3'b111, 3'b001};
      tbl_len = 8;
      run_tbl("prio_sweep");

      // Mid-run reset pulse between edges: grant drops at once, then refills.
      repeat (6) step(3'b010, 1'b0);
      for (int k = 0; k < 3; k++) chk("pre_pulse", dly(k), gnt_of(k), 3'b010);
      #2;
      rst_n = 1'b0;
      hist.delete();
      #1;
      for (int k = 0; k < 3; k++) chk("async_clear", dly(k), gnt_of(k), 3'b000);
      #1;
      rst_n = 1'b1;
      for (int j = 1; j <= 6; j++) begin
         step(3'b010, 1'b0);
         for (int k = 0; k < 3; k++)
            chk("post_pulse", dly(k), gnt_of(k), (j >= dly(k)) ? 3'b010 : 3'b000);
      end

      // Random traffic against the model.
      for (int j = 0; j < 1000; j++) step(3'($urandom_range(0, 7)), 1'b0);
      $display("random: 1000 cycles compared against model");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pri_arb.md
Name: pri_arb

Overview:
- Fixed-priority N-way request arbiter with a parameterisable, fully pipelined grant latency.
- Bit 0 of `req` has the highest priority.
- The one-hot grant for the request vector sampled at clock edge t appears on `gnt` exactly DELAY cycles later.
- Used wherever a shared resource needs a deterministic, latency-matched grant.

Parameters:
- N, default 3: number of requesters (width of `req`/`gnt`); legal N >= 1.
- DELAY, default 2: grant latency in clock cycles; legal DELAY >= 1; DELAY = 0 is rejected with an elaboration-time error.

Ports:
- clk, input, 1: clock; all state updates on rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- req, input, N: request vector; bit i high means requester i is requesting.
- gnt, output, N: grant vector; one-hot or all-zero; registered output.

Behaviour:
- Encoding: enc(r) = one-hot of the lowest-index set bit of r; enc(0) = 0.
  - N=3 examples: 001->001, 010->010, 011->001, 1x0 with bit1=0 -> 100, 110->010, 111->001, 000->000.
- Pipeline: exactly DELAY registered stages, s1..sDELAY.
  - Each rising edge: s1 <= enc(req); sk <= s(k-1) for k = 2..DELAY.
  - gnt = sDELAY.
- Timing: the request value sampled at edge t is visible on `gnt` as sampled at edge t+DELAY.
  - Equivalently, `gnt` updates on edge t+DELAY-1.
  - The encoder is placed before s1; output is never combinational from `req`.
- No request-hold or handshake requirement. Every cycle is an independent sample, so back-to-back different requests produce back-to-back different grants.
- No fairness or rotation: a permanently asserted req[0] starves all others; this is intended.
- Invariant: `gnt` is one-hot or zero on every cycle, including during and after reset.
- Reset:
  - rst_n low clears all stages immediately (asynchronously), so gnt = 0 while rst_n is low.
  - Release is synchronous-safe: the first edge with rst_n high samples `req` normally.
- Reset mid-operation: in-flight grants are discarded. After release, gnt stays 0 until DELAY edges after the first sampled non-zero `req`.
- X on `req`: no requirement beyond simulation propagation; benches drive known values.

Optional Feature:
- Macro PRI_ARB_ASSERT_EN.
- When defined, the module contains concurrent assertions, clocked on clk and disabled while rst_n is low:
  - gnt is $onehot0 on every edge.
  - For any edge where `req` changed, gnt at DELAY edges later equals enc of that `req`.
  - Assertion failures report with $error including the `req` and `gnt` values.
- When not defined, no assertion code is compiled.
- Functional RTL is identical in both cases.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with req=3'b111 -> gnt=000 throughout. Release -> gnt stays 000 for DELAY-1 further edges, then becomes 001.
- Single requests, N=3, DELAY=5: req 001 at edge t, 010 at t+1, 000 at t+2 and t+3, 111 at t+4 -> gnt sampled at edges t+5..t+9 reads 001, 010, 000, 000, 001.
- Priority sweep, N=3: apply all 8 req values, one per cycle -> gnt after DELAY cycles matches enc for each value (e.g. 110->010, 100->100, 101->001).
- Latency parameter: rerun the single-request sequence with DELAY=1 and DELAY=2 -> same grant sequence, shifted to exactly DELAY cycles after each request.
- Mid-run reset: req=010 steady, pulse rst_n low for half a cycle between edges -> gnt drops to 000 immediately. gnt returns to 010 DELAY edges after the first post-release edge.
- Onehot check: random req for 1000 cycles with PRI_ARB_ASSERT_EN defined -> no assertion failures and a scoreboard match every cycle.
